// File: rtl/combo_pkg.sv
// Shared types for the combination-lock code sequencer.
// Optional retry support is enabled with the COMBO_RETRY_EN macro (see combo_sequencer).
package combo_pkg;

    typedef enum logic [2:0] {IDLE, PRESS, GAP, WAIT_LOCK, REPORT} seq_state_t;

    // bit0 = a, bit1 = b, bit2 = c
    typedef logic [2:0] button_t;

    localparam button_t BTN_NONE = 3'b000;

    function automatic int max3(input int x, input int y, input int z);
        int m;
        m = (x > y) ? x : y;
        return (m > z) ? m : z;
    endfunction

endpackage

// File: rtl/combo_sequencer_hold_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
// A state lasting N cycles loads N-1 on entry and leaves when expired_o is seen.
module hold_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/combo_sequencer.sv
// Plays a stored multi-step button code onto a/b/c of the lock FSM and reports pass/fail.
// Define COMBO_RETRY_EN to retry failed attempts (adds the attempts output).
module combo_sequencer
    import combo_pkg::*;
#(
    parameter int                 STEPS       = 4,
    parameter int                 HOLD_CYCLES = 5,
    parameter int                 GAP_CYCLES  = 1,
    parameter int                 LOCK_WAIT   = 8,
    parameter logic [3*STEPS-1:0] CODE_RST    = 12'hB9D,
    parameter int                 MAX_RETRY   = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic [3*STEPS-1:0] code_in,
    input  logic               start,
    input  logic               abort,
    input  logic               lock,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               busy,
    output logic               done,
    output logic               pass
`ifdef COMBO_RETRY_EN
    ,
    output logic [$clog2(MAX_RETRY+2)-1:0] attempts
`endif
);

    localparam int TW = $clog2(max3(HOLD_CYCLES, GAP_CYCLES, LOCK_WAIT) + 1);
    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);
    localparam logic [TW-1:0] HOLD_LD   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD    = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TW-1:0] WAIT_LD   = TW'(LOCK_WAIT - 1);

    seq_state_t         state_q, state_d;
    logic [SW-1:0]      step_q, step_d;
    logic [3*STEPS-1:0] code_q, code_d;
    logic               pass_q, pass_d;
    button_t            btn_q, btn_d;
    logic               tmr_load, tmr_exp;
    logic [TW-1:0]      tmr_val;

`ifdef COMBO_RETRY_EN
    localparam int AW = $clog2(MAX_RETRY + 2);
    logic [AW-1:0] att_q, att_d;
`endif

    hold_timer #(.W(TW)) u_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .load_i    (tmr_load),
        .val_i     (tmr_val),
        .expired_o (tmr_exp)
    );

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        code_d   = code_q;
        pass_d   = pass_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
`ifdef COMBO_RETRY_EN
        att_d    = att_q;
`endif
        case (state_q)
            IDLE: begin
                if (load) code_d = code_in;
                if (start) begin
                    state_d  = PRESS;
                    step_d   = '0;
                    pass_d   = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
`ifdef COMBO_RETRY_EN
                    att_d    = AW'(1);
`endif
                end
            end
            PRESS: begin
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        tmr_val = GAP_LD;
                    end else if (step_q != LAST_STEP) begin
                        step_d  = step_q + SW'(1);
                        tmr_val = HOLD_LD;
                    end else begin
                        state_d = WAIT_LOCK;
                        tmr_val = WAIT_LD;
                    end
                end
            end
            GAP: begin
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    if (step_q != LAST_STEP) begin
                        state_d = PRESS;
                        step_d  = step_q + SW'(1);
                        tmr_val = HOLD_LD;
                    end else begin
                        state_d = WAIT_LOCK;
                        tmr_val = WAIT_LD;
                    end
                end
            end
            WAIT_LOCK: begin
                // lock wins even on the timeout cycle
                if (lock) begin
                    state_d = REPORT;
                    pass_d  = 1'b1;
                end else if (tmr_exp) begin
`ifdef COMBO_RETRY_EN
                    if (att_q <= AW'(MAX_RETRY)) begin
                        state_d  = PRESS;
                        step_d   = '0;
                        att_d    = att_q + AW'(1);
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_LD;
                    end else begin
                        state_d = REPORT;
                    end
`else
                    state_d = REPORT;
`endif
                end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d  = IDLE;
            step_d   = '0;
            code_d   = code_q;
            pass_d   = pass_q;
            tmr_load = 1'b1;
            tmr_val  = '0;
`ifdef COMBO_RETRY_EN
            att_d    = att_q;
`endif
        end

        // Buttons are registered, so they follow the next state
        btn_d = (state_d == PRESS) ? code_d[3*int'(step_d) +: 3] : BTN_NONE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            code_q  <= CODE_RST;
            pass_q  <= 1'b0;
            btn_q   <= BTN_NONE;
`ifdef COMBO_RETRY_EN
            att_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            code_q  <= code_d;
            pass_q  <= pass_d;
            btn_q   <= btn_d;
`ifdef COMBO_RETRY_EN
            att_q   <= att_d;
`endif
        end
    end

    assign {c, b, a} = btn_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == REPORT);
    assign pass      = pass_q;
`ifdef COMBO_RETRY_EN
    assign attempts  = att_q;
`endif

endmodule

// File: tb/tb_combo_sequencer.sv
// Randomised bench for combo_sequencer against a queue-based model of the press/wait timeline.
module tb_combo_sequencer;

    localparam int STEPS = 4, HOLD = 5, GAP = 1, LW = 8, MAX_RETRY = 2;
    localparam int CW = 3 * STEPS;
    localparam int SEQ = STEPS * (HOLD + GAP);
    localparam logic [CW-1:0] CODE_RST = 12'hB9D;
`ifdef COMBO_RETRY_EN
    localparam int MAX_ATT = MAX_RETRY + 1;
`else
    localparam int MAX_ATT = 1;
`endif

    logic clock = 1'b0, reset_n = 1'b1;
    logic load = 1'b0, start = 1'b0, abort = 1'b0, lock = 1'b0;
    logic [CW-1:0] code_in = '0;
    logic a, b, c, busy, done, pass;
`ifdef COMBO_RETRY_EN
    logic [$clog2(MAX_RETRY+2)-1:0] attempts;
`endif

    int n_checks = 0, n_fail = 0;
    logic [CW-1:0] code_m;

    always #5 clock = ~clock;

    combo_sequencer #(
        .STEPS(STEPS), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .LOCK_WAIT(LW),
        .CODE_RST(CODE_RST), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clock(clock), .reset_n(reset_n), .load(load), .code_in(code_in),
        .start(start), .abort(abort), .lock(lock),
        .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass)
`ifdef COMBO_RETRY_EN
        , .attempts(attempts)
`endif
    );

    // lock_cycle: first cycle after start (1-based) at which lock is high; 0 = never
    task automatic run_seq(input string name, input logic [CW-1:0] code, input logic do_load,
                           input int lock_cycle, input logic junk);
        logic [2:0] q[$];
        logic [2:0] eb;
        logic [4:0] exp_v, got_v;
        logic exp_pass;
        int total, att;
        if (do_load) code_m = code;
        exp_pass = 1'b0;
        att = 0;
        for (int r = 0; r < MAX_ATT && !exp_pass; r++) begin
            att++;
            for (int k = 0; k < STEPS; k++) begin
                repeat (HOLD) q.push_back(code_m[3*k +: 3]);
                repeat (GAP) q.push_back(3'b000);
            end
            for (int j = 0; j < LW; j++) begin
                q.push_back(3'b000);
                if (lock_cycle != 0 && q.size() >= lock_cycle) begin
                    exp_pass = 1'b1;
                    break;
                end
            end
        end
        total = q.size() + 1;

        @(negedge clock); load = do_load; code_in = code; start = 1'b1;
        @(negedge clock); load = 1'b0; start = 1'b0;
        for (int n = 1; n <= total + 1; n++) begin
            eb = (n < total) ? q[n-1] : 3'b000;
            exp_v = {(n <= total), (n == total), eb};
            got_v = {busy, done, c, b, a};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s cyc %0d {busy,done,c,b,a}: got %b expected %b", name, n, got_v, exp_v);
            end
            if (n >= total) begin
                n_checks++;
                if (pass !== exp_pass) begin
                    n_fail++;
                    $display("FAIL %s cyc %0d pass: got %b expected %b", name, n, pass, exp_pass);
                end
`ifdef COMBO_RETRY_EN
                n_checks++;
                if ($isunknown(attempts) || int'(attempts) != att) begin
                    n_fail++;
                    $display("FAIL %s attempts: got %0d expected %0d", name, attempts, att);
                end
`endif
            end
            lock = (lock_cycle != 0 && n >= lock_cycle && n < total);
            if (junk) begin
                start = (n == 10);
                load  = (n == 10);
                if (n == 10) code_in = CW'($urandom);
            end
            @(negedge clock);
        end
        lock = 1'b0; start = 1'b0; load = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #2;
        n_checks++;
        if ({busy, done, c, b, a, pass} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000000", {busy, done, c, b, a, pass});
        end
        @(negedge clock); reset_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({busy, done, c, b, a, pass} !== 6'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b expected 000000", {busy, done, c, b, a, pass});
        end
        code_m = CODE_RST;
    endtask

    task automatic test_default_pass();
        run_seq("default_pass", '0, 1'b0, SEQ + 2, 1'b0);
    endtask

    task automatic test_no_lock();
        run_seq("no_lock", '0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_zero_code();
        run_seq("zero_code", '0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_last_cycle_lock();
        run_seq("last_cycle_lock", CODE_RST, 1'b1, SEQ + LW, 1'b0);
    endtask

    task automatic test_abort();
        logic [2:0] exp_b;
        exp_b = code_m[6 +: 3];
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (13) @(negedge clock);
        n_checks++;
        if ({c, b, a} !== exp_b) begin
            n_fail++;
            $display("FAIL abort_step2_press: got %b expected %b", {c, b, a}, exp_b);
        end
        abort = 1'b1;
        @(negedge clock); abort = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({busy, done, c, b, a} !== 5'b0) begin
                n_fail++;
                $display("FAIL abort_idle cyc %0d: got %b expected 00000", i, {busy, done, c, b, a});
            end
            @(negedge clock);
        end
        run_seq("after_abort", '0, 1'b0, SEQ + 3, 1'b0);
    endtask

    task automatic test_async_reset();
        @(negedge clock); load = 1'b1; code_in = ~CODE_RST; start = 1'b1;
        @(negedge clock); load = 1'b0; start = 1'b0;
        repeat (5) @(negedge clock);
        n_checks++;
        if ({busy, c, b, a} !== 4'b1000) begin
            n_fail++;
            $display("FAIL mid_gap_state: got %b expected 1000", {busy, c, b, a});
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, c, b, a, pass} !== 6'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected 000000", {busy, done, c, b, a, pass});
        end
        start = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_reset: got busy %b expected 0", busy);
        end
        start = 1'b0; reset_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_release: got busy %b expected 0", busy);
        end
        code_m = CODE_RST;
        run_seq("code_after_reset", '0, 1'b0, SEQ + 1, 1'b0);
    endtask

    task automatic test_random();
        logic [CW-1:0] code;
        logic dl;
        int sel, lc;
        for (int i = 0; i < 8; i++) begin
            code = CW'($urandom);
            dl   = 1'($urandom_range(0, 1));
            sel  = int'($urandom_range(0, 2));
            if (sel == 0) lc = 0;
            else if (sel == 1) lc = SEQ + int'($urandom_range(1, LW));
            else lc = int'($urandom_range(1, SEQ));
            run_seq("random", code, dl, lc, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_default_pass();
        test_no_lock();
        test_zero_code();
        test_last_cycle_lock();
        test_abort();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
